count_sched: RTL

Round-robin scheduler that shares one up/down counter between NREQ requesters. Each requester asks for one counting job: a start value, a target value and a direction. The block grants one job at a time, loads the counter, enables it until the count hits the target or wraps, then returns a done/error pulse to the owner. It sits between the requester logic and the counter's control/status pins.

---
 rtl/count_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one up/down counter among NREQ jobs.
// Define COUNT_SCHED_RR_EN for round-robin grants; otherwise lowest index wins.
module count_sched #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ-1:0]       i_dir,
    input  logic [NREQ*WIDTH-1:0] i_start,
    input  logic [NREQ*WIDTH-1:0] i_target,
    output logic [NREQ-1:0]       o_done,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [IDW-1:0]        o_gnt_id,
    output logic                  o_cnt_en,
    output logic                  o_cnt_up_down,
    output logic                  o_cnt_load,
    output logic [WIDTH-1:0]      o_cnt_load_data,
    input  logic [WIDTH-1:0]      i_cnt_count,
    input  logic                  i_cnt_ovf,
    input  logic                  i_cnt_udf
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDW-1:0]   gnt;
    logic [IDW-1:0]   pick;
    logic             found;
    logic             dir_q;
    logic             err_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] target_q;
    logic             hit;
    logic             wrap;
    logic             grant;

    assign hit   = (i_cnt_count == target_q);
    assign wrap  = i_cnt_ovf | i_cnt_udf;
    assign grant = (state == IDLE) && found;

`ifdef COUNT_SCHED_RR_EN
    logic [IDW-1:0] ptr;
    logic [IDW:0]   idx;

    // Round-robin search: first requester at or after the pointer
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && i_req[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    // Pointer moves just past the requester granted last
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            ptr <= '0;
        else if (grant)
            ptr <= (pick == IDW'(NREQ-1)) ? '0 : pick + 1'b1;
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (i_req[i]) begin
                found = 1'b1;
                pick  = IDW'(i);
            end
        end
    end
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Job values are captured once at grant and held for the whole job
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt      <= '0;
            dir_q    <= 1'b0;
            start_q  <= '0;
            target_q <= '0;
        end else if (grant) begin
            gnt      <= pick;
            dir_q    <= i_dir[pick];
            start_q  <= i_start[int'(pick)*WIDTH +: WIDTH];
            target_q <= i_target[int'(pick)*WIDTH +: WIDTH];
        end
    end

    // Error flag tracks wrap while running; its last value is the verdict
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            err_q <= 1'b0;
        else if (state == RUN)
            err_q <= wrap;
    end

    // Next-state logic; wrap beats hit when both appear together
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (found) state_nx = LOAD;
            LOAD: state_nx = RUN;
            RUN:  if (wrap || hit) state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; enable is combinational so no overshoot
    always_comb begin
        o_busy          = (state != IDLE);
        o_cnt_load      = (state == LOAD);
        o_cnt_load_data = (state == LOAD) ? start_q : '0;
        o_cnt_en        = (state == RUN) && !hit && !wrap;
        o_cnt_up_down   = (state != IDLE) && dir_q;
        o_done          = '0;
        o_err           = 1'b0;
        if (state == DONE) begin
            o_done = NREQ'(1) << gnt;
            o_err  = err_q;
        end
        o_gnt_id = gnt;
    end

endmodule
